jpeg_dequant_ctrl: RTL

Sequenced, table-driven dequantizer. It stores up to four quantization tables written by the DQT header parser. It streams one row-major coefficient per cycle from the inverse-zigzag stage through a single shared multiplier, and emits dequantized coefficients toward the IDCT with block framing. It replaces the 64-multiplier flat datapath with one multiplier plus a 64-count block scheduler and valid/ready handshakes.

---
 rtl/jpeg_dequant_ctrl.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/jpeg_dequant_ctrl.sv
// jpeg_dequant_ctrl: table-driven JPEG dequantizer built around one shared
// multiplier. Four 64-entry quant tables are loaded by the DQT parser while
// idle. A block scheduler then streams 64 row-major coefficients through a
// two-stage multiply pipeline toward the IDCT, with valid/ready on both sides.
// Optional build macro: JPEG_DEQUANT_SAT_EN clamps each product to the 16-bit
// signed range before it is sign-extended onto out_data.
module jpeg_dequant_ctrl #(
    parameter int WIDTH_IN  = 16,
    parameter int WIDTH_Q   = 16,
    parameter int WIDTH_OUT = 32
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        qt_wr_en,
    input  logic [1:0]                  qt_wr_sel,
    input  logic [5:0]                  qt_wr_addr,
    input  logic [WIDTH_Q-1:0]          qt_wr_data,
    output logic                        qt_wr_ready,
    input  logic                        blk_start,
    input  logic [1:0]                  blk_qsel,
    output logic                        busy,
    input  logic                        in_valid,
    input  logic signed [WIDTH_IN-1:0]  in_data,
    output logic                        in_ready,
    output logic                        out_valid,
    output logic signed [WIDTH_OUT-1:0] out_data,
    output logic                        out_last,
    input  logic                        out_ready,
    output logic                        blk_done
);

    // Full-precision product width: signed coefficient times non-negative entry.
    localparam int PW = WIDTH_IN + WIDTH_Q + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } state_t;

    state_t                      state_q, state_d;
    logic [5:0]                  idx_q, idx_d;
    logic [1:0]                  qsel_q, qsel_d;
    logic                        blk_done_q;

    logic [WIDTH_Q-1:0]          qtab_q [4][64];

    logic                        vld_p1_q;
    logic signed [WIDTH_IN-1:0]  coef_p1_q;
    logic [WIDTH_Q-1:0]          qent_p1_q;
    logic                        last_p1_q;

    logic                        vld_p2_q;
    logic signed [WIDTH_OUT-1:0] data_p2_q;
    logic                        last_p2_q;

    logic                        stall;
    logic                        accept;
    logic                        last_taken;
    logic signed [PW-1:0]        prod_p1;

`ifdef JPEG_DEQUANT_SAT_EN
    localparam logic signed [PW-1:0] SAT_MAX = PW'(32767);
    localparam logic signed [PW-1:0] SAT_MIN = PW'(-32768);
`endif

    // Map the full-precision product onto the output width (clamped when enabled).
    function automatic logic signed [WIDTH_OUT-1:0] fit_out(input logic signed [PW-1:0] p);
`ifdef JPEG_DEQUANT_SAT_EN
        if (p > SAT_MAX) begin
            return WIDTH_OUT'(SAT_MAX);
        end else if (p < SAT_MIN) begin
            return WIDTH_OUT'(SAT_MIN);
        end
        return WIDTH_OUT'(p);
`else
        return WIDTH_OUT'(p);
`endif
    endfunction

    // A held output beat freezes every stage, so nothing upstream may advance.
    assign stall       = vld_p2_q && !out_ready;
    assign in_ready    = (state_q == RUN) && !stall;
    assign accept      = in_valid && in_ready;
    assign last_taken  = vld_p2_q && out_ready && last_p2_q;
    assign qt_wr_ready = (state_q == IDLE);
    assign busy        = (state_q != IDLE);
    assign out_valid   = vld_p2_q;
    assign out_data    = data_p2_q;
    assign out_last    = last_p2_q;
    assign blk_done    = blk_done_q;

    // Entry is zero-extended by one bit so the multiply stays signed throughout.
    assign prod_p1 = PW'(coef_p1_q) * PW'($signed({1'b0, qent_p1_q}));

    // Block scheduler next-state: start latches the table, 64 accepts, then drain.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        qsel_d  = qsel_q;
        case (state_q)
            IDLE: begin
                if (blk_start) begin
                    state_d = RUN;
                    qsel_d  = blk_qsel;
                    idx_d   = 6'd0;
                end
            end
            RUN: begin
                if (accept) begin
                    idx_d = idx_q + 6'd1;
                    if (idx_q == 6'd63) begin
                        state_d = FLUSH;
                    end
                end
            end
            FLUSH: begin
                if (last_taken) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Scheduler registers and the block-done pulse following the last output beat.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            idx_q      <= 6'd0;
            qsel_q     <= 2'd0;
            blk_done_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            qsel_q     <= qsel_d;
            blk_done_q <= (state_q == FLUSH) && last_taken;
        end
    end

    // Quant table storage; reset restores unity gain so data passes unchanged.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int t = 0; t < 4; t++) begin
                for (int e = 0; e < 64; e++) begin
                    qtab_q[t][e] <= WIDTH_Q'(1);
                end
            end
        end else if (qt_wr_en && qt_wr_ready) begin
            qtab_q[qt_wr_sel][qt_wr_addr] <= qt_wr_data;
        end
    end

    // Stage 1: capture the accepted coefficient with its table entry.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p1_q  <= 1'b0;
            last_p1_q <= 1'b0;
        end else if (!stall) begin
            vld_p1_q  <= accept;
            last_p1_q <= accept && (idx_q == 6'd63);
        end
    end

    // Stage 1 data path (no reset needed; qualified by vld_p1_q).
    always_ff @(posedge clk) begin
        if (!stall && accept) begin
            coef_p1_q <= in_data;
            qent_p1_q <= qtab_q[qsel_q][idx_q];
        end
    end

    // Stage 2: register the product; held unchanged while downstream stalls.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p2_q  <= 1'b0;
            last_p2_q <= 1'b0;
            data_p2_q <= '0;
        end else if (!stall) begin
            vld_p2_q  <= vld_p1_q;
            last_p2_q <= vld_p1_q && last_p1_q;
            if (vld_p1_q) begin
                data_p2_q <= fit_out(prod_p1);
            end
        end
    end

endmodule
